// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
package imem_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;
  localparam int BIDX_W         = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_BYTES,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  import imem_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  // master: the byte source / memory side; slave: the loader itself
  modport master (output in_valid, in_data,
                  input  in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler; word_ready marks the byte completing a word.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);
  logic [BIDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= {word[WORD_W-9:0], din};
      idx  <= idx + 1'b1;
    end
  end

  assign word_ready = shift_en && (idx == BIDX_W'(BYTES_PER_WORD-1));
endmodule

// File: rtl/imem_loader.sv
// Boot loader: header-counted byte stream -> sequential instruction memory writes,
// holding the CPU in reset until a good image has been written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [33:0] LAST_BYTE = {2'b00, BASE_ADDR} + 34'(DEPTH-1) * 34'd4;

  generate
    if (BASE_ADDR[1:0] != 2'b00 || LAST_BYTE[33:32] != 2'b00) begin : g_bad_cfg
      $error("imem_loader: BASE_ADDR misaligned or image address range wraps");
    end
  endgenerate

  state_e            state;
  logic [HDR_W-1:0]  count;
  logic [HDR_W-1:0]  wcnt;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] word;
  logic              word_ready;
  logic              xfer;
  logic              launch;
  logic [HDR_W-1:0]  hdr_full;
  logic [HDR_W-1:0]  wcnt_nxt;

  assign bus.in_ready  = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_BYTES);
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign launch   = start && ((state == S_IDLE) || (state == S_DONE));
  assign hdr_full = {count[HDR_W-1:8], bus.in_data};
  assign wcnt_nxt = wcnt + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (launch),
    .shift_en   (xfer && (state == S_BYTES)),
    .din        (bus.in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      wcnt     <= '0;
      addr     <= BASE_ADDR;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (launch) begin
          state    <= S_HDR_HI;
          done     <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b1;
          cpu_hold <= 1'b1;
          wcnt     <= '0;
          addr     <= BASE_ADDR;
        end
        S_HDR_HI: if (xfer) begin
          count[HDR_W-1:8] <= bus.in_data;
          state            <= S_HDR_LO;
        end
        S_HDR_LO: if (xfer) begin
          count[7:0] <= bus.in_data;
          if (hdr_full == '0) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (32'(hdr_full) > 32'(DEPTH)) begin
            // oversized image: report and keep the CPU parked in reset
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state <= S_BYTES;
          end
        end
        S_BYTES: if (word_ready) state <= S_WRITE;
        S_WRITE: begin
          addr <= addr + 32'd4;
          wcnt <= wcnt_nxt;
          if (wcnt_nxt == count) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state <= S_BYTES;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are queued from the
// image contents, and a monitor pops and checks each mem_we cycle.
module tb_imem_loader;
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      chk("in_ready_on_write", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", bus.mem_addr, e.addr);
        chk("write_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // optional idle gap, then hold the byte until it is accepted
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    bit rdy;
    int budget;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(gapmax, 0)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      tick();
      budget++;
    end while (!rdy && budget < 50);
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_accept_timeout: got no in_ready expected accept within 50 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gapmax);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!done && budget < 200) begin
      tick();
      budget++;
    end
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  // image model: a good image lands at BASE + 4*i; zero or oversized counts write nothing
  task automatic run_load(input string tag, input int cnt, input logic [31:0] w[$],
                          input int gapmax);
    bit bad = (cnt > DEPTH);
    while (w.size() < cnt) w.push_back($urandom);
    if (!bad)
      for (int i = 0; i < cnt; i++) exp_q.push_back('{BASE + 32'(4 * i), w[i]});
    pulse_start();
    send_byte(8'(cnt >> 8), gapmax);
    send_byte(8'(cnt), gapmax);
    if (cnt == 0 || bad) begin
      chk({tag, "_done_next_cycle"}, 32'(done), 32'd1);
    end else begin
      for (int i = 0; i < cnt; i++) send_word(w[i], gapmax);
      wait_done();
    end
    chk({tag, "_err"}, 32'(err), 32'(bad));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(bad));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, BASE);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] img16[$];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    repeat (10) tick();
    chk_reset_vals("idle_no_start");

    img = '{32'h2008_0005, 32'h8C09_0004};
    run_load("two_words", 2, img, 0);

    img = {};
    run_load("empty", 0, img, 0);
    run_load("too_big", 257, img, 0);
    run_load("max_depth_boundary", DEPTH, img, 0);

    img16 = {};
    for (int i = 0; i < 16; i++) img16.push_back($urandom);
    run_load("gapfree16", 16, img16, 0);
    run_load("gappy16", 16, img16, 3);

    for (int r = 0; r < 4; r++) run_load("random", int'($urandom_range(20, 1)), img, 2);

    // reset in the middle of word 3: only words 0..2 may appear
    for (int i = 0; i < 3; i++) exp_q.push_back('{BASE + 32'(4 * i), img16[i]});
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h10, 1);
    for (int i = 0; i < 3; i++) send_word(img16[i], 1);
    send_byte(img16[3][31:24], 1);
    send_byte(img16[3][23:16], 1);
    rst_n = 1'b0;
    #2;
    chk_reset_vals("mid_word_reset");
    chk("mid_word_pending", 32'(exp_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_reset_vals("after_reset_release");
    run_load("reload16", 16, img16, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
